mul32p_arb: RTL and testbench

Two-port arbiter and sequencer for the shared pipelined 32-bit Dadda multiplier (`mul32p`). It accepts multiply requests from two independent requesters over valid/ready handshakes and issues at most one operation per cycle into the multiplier. Because the multiplier carries no valid or tag, the block tracks each in-flight operation in a shadow pipeline and routes each result back to the requester that issued it. It sits between the execution units and the single `mul32p` instance.

---
 rtl/mul32p_arb.sv | 146 ++++++++++++++
 tb/tb_mul32p_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mul32p_arb.sv
// Two-port round-robin front end for the shared pipelined multiplier.
// A shadow {valid, id} pipeline tracks each in-flight product so its result can be routed back.
module mul32p_arb #(
  parameter int unsigned LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_mode,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_mode,

  output logic        resp0_valid,
  output logic [31:0] resp0_lo,
  output logic [31:0] resp0_hi,
  output logic        resp1_valid,
  output logic [31:0] resp1_lo,
  output logic [31:0] resp1_hi,

  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_mode,
  input  logic [31:0] mul_lo,
  input  logic [31:0] mul_hi,

  output logic        idle
);

  localparam int unsigned Depth = LAT + 1;

  logic last_q;
  logic grant0, grant1;
  logic xfer0, xfer1, xfer;

  logic [Depth-1:0] sv_q;
  logic [Depth-1:0] sid_q;
  logic             tail_valid, tail_id;

  logic [31:0] mul_a_q, mul_b_q;
  logic        mul_mode_q;

  logic        resp0_valid_q, resp1_valid_q;
  logic [31:0] resp0_lo_q, resp0_hi_q, resp1_lo_q, resp1_hi_q;

  // On conflict, the requester that did not win last time is served.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_q;
      grant1 = ~last_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;

  assign xfer0 = req0_valid & req0_ready;
  assign xfer1 = req1_valid & req1_ready;
  assign xfer  = xfer0 | xfer1;

  assign tail_valid = sv_q[LAT];
  assign tail_id    = sid_q[LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q     <= 1'b1;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_mode_q <= 1'b0;
    end else if (xfer0) begin
      last_q     <= 1'b0;
      mul_a_q    <= req0_a;
      mul_b_q    <= req0_b;
      mul_mode_q <= req0_mode;
    end else if (xfer1) begin
      last_q     <= 1'b1;
      mul_a_q    <= req1_a;
      mul_b_q    <= req1_b;
      mul_mode_q <= req1_mode;
    end
  end

  // Shadow pipeline: shifts unconditionally, tail aligned with mul_lo/mul_hi.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sv_q  <= '0;
      sid_q <= '0;
    end else begin
      sv_q[0]  <= xfer;
      sid_q[0] <= xfer1;
      for (int unsigned i = 1; i < Depth; i++) begin
        sv_q[i]  <= sv_q[i-1];
        sid_q[i] <= sid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_lo_q    <= '0;
      resp0_hi_q    <= '0;
      resp1_lo_q    <= '0;
      resp1_hi_q    <= '0;
    end else begin
      resp0_valid_q <= tail_valid & ~tail_id;
      resp1_valid_q <= tail_valid & tail_id;
      if (tail_valid && !tail_id) begin
        resp0_lo_q <= mul_lo;
        resp0_hi_q <= mul_hi;
      end
      if (tail_valid && tail_id) begin
        resp1_lo_q <= mul_lo;
        resp1_hi_q <= mul_hi;
      end
    end
  end

  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign mul_mode = mul_mode_q;

  assign resp0_valid = resp0_valid_q;
  assign resp0_lo    = resp0_lo_q;
  assign resp0_hi    = resp0_hi_q;
  assign resp1_valid = resp1_valid_q;
  assign resp1_lo    = resp1_lo_q;
  assign resp1_hi    = resp1_hi_q;

  // A result still counts as in flight during its response strobe.
  assign idle = ~rst_n | (~|sv_q & ~resp0_valid_q & ~resp1_valid_q & ~xfer);

endmodule

// File: tb/tb_mul32p_arb.sv
// Randomized and directed bench for mul32p_arb against a transaction-level model
// (expected-response queue keyed by due cycle), with a behavioural LAT-stage multiplier.
module tb_mul32p_arb;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_mode;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_mode;
  logic [31:0] req1_a, req1_b;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp0_lo, resp0_hi, resp1_lo, resp1_hi;
  logic [31:0] mul_a, mul_b, mul_lo, mul_hi;
  logic        mul_mode;
  logic        idle;

  mul32p_arb #(.LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_mode  (req0_mode),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_mode  (req1_mode),
    .resp0_valid(resp0_valid),
    .resp0_lo   (resp0_lo),
    .resp0_hi   (resp0_hi),
    .resp1_valid(resp1_valid),
    .resp1_lo   (resp1_lo),
    .resp1_hi   (resp1_hi),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_mode   (mul_mode),
    .mul_lo     (mul_lo),
    .mul_hi     (mul_hi),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b,
                                       input logic m);
    logic signed [63:0] sa, sb;
    if (m) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Behavioural multiplier: operands in cycle c give the product in cycle c+LAT.
  logic [63:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= prod(mul_a, mul_b, mul_mode);
    for (int i = 1; i < int'(LAT); i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_lo = mpipe[LAT-1][31:0];
  assign mul_hi = mpipe[LAT-1][63:32];

  typedef struct {
    int unsigned due;
    logic        port;
    logic [63:0] p;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc;
  int          n_checks = 0;
  int          n_err    = 0;
  logic        m_last;
  logic [63:0] m_resp0, m_resp1;
  logic [31:0] m_mul_a, m_mul_b;
  logic        m_mul_mode;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Drives one cycle just after the edge, checks outputs, then advances the model.
  task automatic step(input logic rn,
                      input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic m0,
                      input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic m1);
    logic g0, g1, x0, x1, ev0, ev1;
    rst_n      = rn;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_mode = m0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_mode = m1;
    #1;
    if (!rn) begin
      g0 = 1'b0; g1 = 1'b0;
    end else if (v0 && v1) begin
      g0 = m_last; g1 = !m_last;
    end else begin
      g0 = v0; g1 = v1;
    end
    x0 = v0 & g0;
    x1 = v1 & g1;
    check("req0_ready", 64'(req0_ready), 64'(g0));
    check("req1_ready", 64'(req1_ready), 64'(g1));
    check("idle", 64'(idle), 64'(!rn || (q.size() == 0 && !(x0 || x1))));
    check("mul_a", 64'(mul_a), 64'(m_mul_a));
    check("mul_b", 64'(mul_b), 64'(m_mul_b));
    check("mul_mode", 64'(mul_mode), 64'(m_mul_mode));

    ev0 = 1'b0; ev1 = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].port) begin ev1 = 1'b1; m_resp1 = q[0].p; end
      else begin ev0 = 1'b1; m_resp0 = q[0].p; end
      void'(q.pop_front());
    end
    check("resp0_valid", 64'(resp0_valid), 64'(ev0));
    check("resp1_valid", 64'(resp1_valid), 64'(ev1));
    check("resp0_data", {resp0_hi, resp0_lo}, m_resp0);
    check("resp1_data", {resp1_hi, resp1_lo}, m_resp1);

    if (x0) begin
      q.push_back('{due: cyc + LAT + 2, port: 1'b0, p: prod(a0, b0, m0)});
      m_last = 1'b0; m_mul_a = a0; m_mul_b = b0; m_mul_mode = m0;
    end else if (x1) begin
      q.push_back('{due: cyc + LAT + 2, port: 1'b1, p: prod(a1, b1, m1)});
      m_last = 1'b1; m_mul_a = a1; m_mul_b = b1; m_mul_mode = m1;
    end
    if (!rn) begin
      q.delete();
      m_last = 1'b1;
      m_resp0 = '0; m_resp1 = '0;
      m_mul_a = '0; m_mul_b = '0; m_mul_mode = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    cyc = 0;
    m_last = 1'b1;
    m_resp0 = '0; m_resp1 = '0;
    m_mul_a = '0; m_mul_b = '0; m_mul_mode = 1'b0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_mode = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with both requesters pushing: ready must stay low.
    step(1'b0, 1'b1, 32'd5, 32'd6, 1'b0, 1'b1, 32'd7, 32'd8, 1'b0);

    // Single unsigned request.
    step(1'b1, 1'b1, 32'd292, 32'd6785, 1'b0, 1'b0, '0, '0, 1'b0);
    idle_steps(LAT + 4);

    // Signed then unsigned interpretation of the same operands on req1.
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b1);
    idle_steps(LAT + 4);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    idle_steps(LAT + 4);

    // Contention straight after reset.
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, rand_op(), rand_op(), 1'($urandom), 1'b1, rand_op(), rand_op(),
           1'($urandom));
    idle_steps(LAT + 4);

    // Single-requester streaming.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, rand_op(), rand_op(), 1'($urandom), 1'b0, '0, '0, 1'b0);
    idle_steps(LAT + 4);

    // Reset mid-flight, then a clean request.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, rand_op(), rand_op(), 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    idle_steps(LAT + 4);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 32'd12345, 32'd678, 1'b0);
    idle_steps(LAT + 4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) < 6), rand_op(), rand_op(), 1'($urandom),
           ($urandom_range(0, 9) < 6), rand_op(), rand_op(), 1'($urandom));
    idle_steps(LAT + 4);
    check("drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
